vbus_arbiter: RTL and testbench
===============================

// Module: vbus_arbiter
// PURPOSE
//  Shares the single 16-bit video/memory-mapped bus (textbuffer, sprite registers) among NREQ
//  requesters (CPU, vsync animator, sprite loader). Round-robin, one single-beat transaction at a
//  time; vsync-priority override for one requester. Drives bus_addr/bus_do/bus_rw/bus_en into the
//  existing address decoder and returns read data to the owning requester.
// PARAMETERS
//  NREQ      3   number of requesters (2..8)
//  ADDR_W    16  bus address width
//  DATA_W    8   bus data width
//  READ_LAT  1   cycles from bus_en cycle to valid bus_di (1..7)
//  VBL_REQ   0   requester index given fixed priority while vsync=1
// PORTS
//  clk       in   1              system clock (PLL 60 MHz)
//  reset     in   1              asynchronous, active-high
//  vsync     in   1              vertical blank window from lcd timing
//  req       in   NREQ           per-requester request, level
//  req_we    in   NREQ           per-requester 1=write 0=read, valid with req
//  req_addr  in   NREQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata in   NREQ*DATA_W    packed write data, same packing
//  gnt       out  NREQ           one-hot, one-cycle pulse: transaction accepted
//  rvalid    out  NREQ           one-hot, one-cycle pulse: rdata valid for requester i
//  rdata     out  DATA_W         read data (shared), valid only with rvalid
//  bus_en    out  1              one-cycle bus strobe
//  bus_rw    out  1              1=write (decoder drives *_we), 0=read (*_oe)
//  bus_addr  out  ADDR_W         bus address
//  bus_do    out  DATA_W         write data to bus
//  bus_di    in   DATA_W         read data from bus mux
//  busy      out  1              state != IDLE
// BEHAVIOUR
//  Interface: one clock clk; reset asynchronous, active-high. All outputs registered.
//  Reset (async, any time): state=IDLE, rr_ptr=0, gnt=0, rvalid=0, rdata=0, bus_en=0, bus_rw=0,
//   bus_addr=0, bus_do=0, wait counter=0. In-flight read abandoned: no rvalid ever issued for it.
//  States: IDLE -> ISSUE -> (write) IDLE | (read) WAIT -> RESP -> IDLE.
//  IDLE: req sampled only here. If any req: winner w chosen; next edge -> ISSUE with gnt[w]=1,
//   bus_en=1, bus_rw=req_we[w], bus_addr/bus_do latched from w's slice, owner<=w. No req: stay.
//  Winner: if vsync=1 and req[VBL_REQ]=1 -> VBL_REQ; else first set req scanning rr_ptr,
//   rr_ptr+1, ... mod NREQ. After any grant rr_ptr <= (w+1) mod NREQ (priority grants included).
//  ISSUE (exactly 1 cycle): gnt and bus_en high; req ignored. Write -> IDLE. Read -> WAIT, cnt<=1.
//  WAIT: bus_en=0, bus_addr held. bus_di valid in cycle E+READ_LAT (E = ISSUE cycle); sampled at
//   the end of that cycle -> RESP with rdata<=bus_di, rvalid[owner]=1 (cycle E+READ_LAT+1).
//  RESP (1 cycle) -> IDLE. rdata holds until next read response.
//  Throughput: write every 2 cycles; read every READ_LAT+3 cycles per the above.
//  Requester rule: drop req (or present next transaction) on the edge where gnt is seen; a req
//   still high in IDLE is a new transaction.
//  vsync toggling mid-transaction: no effect until next IDLE arbitration.
//  Outside ISSUE: bus_en=0, bus_rw=0 (decoder sees no write); gnt/rvalid never multi-hot.
//  req bit of index >= NREQ impossible; req_we/addr/wdata of non-winners ignored.
// TESTING
//  T1 reset: assert reset mid-WAIT of a read -> all outputs 0 same cycle; no rvalid after release.
//  T2 single write: req[1]=1 we=1 addr=FC03 data=05 -> next cycle gnt=010, bus_en=1,
//   bus_rw=1, bus_addr=FC03, bus_do=05; following cycle bus_en=0, busy=0.
//  T3 read, READ_LAT=1: req[2] read FBF8, model bus_di=4E one cycle after bus_en ->
//   rvalid=100, rdata=4E exactly 2 cycles after gnt; 1 cycle later busy=0.
//  T4 round-robin: req=111 held, vsync=0 -> grant order 0,1,2,0,1,2 (rr_ptr from 0), write every
//   2 cycles; no requester starved over 30 grants.
//  T5 vsync priority: rr_ptr=1, req=011, vsync=1 -> gnt=001; then rr_ptr=1, vsync=0 -> gnt=010.
//  T6 gnt/rvalid one-hot and bus_en single-cycle checked by assertion across random traffic,
//   READ_LAT=1 and 3; read data scoreboard matches memory model.

Source files
------------

// File: rtl/vbus_arbiter.sv
// -----------------------------------------------------------------------------
// vbus_arbiter
//   Shares the single video/memory-mapped bus (textbuffer, sprite registers)
//   among NREQ requesters. Round-robin arbitration, one single-beat transaction
//   in flight at a time, with a fixed-priority override for requester VBL_REQ
//   while vsync is high. Drives bus_en/bus_rw/bus_addr/bus_do into the address
//   decoder and returns read data (bus_di) to the requester that owns the read.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   vsync                 vertical blank window (enables the priority override)
//   req, req_we           per-requester request level and 1=write / 0=read
//   req_addr, req_wdata   packed per-requester address / write data,
//                         requester i at [i*W +: W]
//   gnt                   one-hot, one-cycle pulse: transaction accepted
//   rvalid, rdata         one-hot, one-cycle read response; rdata shared, held
//   bus_en, bus_rw        one-cycle bus strobe, 1=write 0=read
//   bus_addr, bus_do      bus address / write data
//   bus_di                read data from the bus mux
//   busy                  arbiter is not idle
//   dbg_state             current FSM state (IDLE=0 ISSUE=1 WAIT=2 RESP=3)
//
// Handshake: a requester holds req (with req_we/addr/wdata stable) until it
// sees its gnt bit; it must drop req or present its next transaction on that
// edge, because a req still high when the arbiter returns to IDLE is taken as
// a new transaction. Reads are answered later by exactly one rvalid pulse.
// -----------------------------------------------------------------------------
module vbus_arbiter #(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1,
  parameter int VBL_REQ  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vsync,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     bus_en,
  output logic                     bus_rw,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_do,
  input  logic [DATA_W-1:0]        bus_di,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                bus_en_q, bus_en_d;
  logic                bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_do_q, bus_do_d;
  logic                busy_q, busy_d;

  // Winner selection and the winner's request fields.
  logic                win_valid;
  logic [PTR_W-1:0]    win_idx;
  logic [NREQ-1:0]     win_oh;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

  // Round-robin as two passes: first the requesters at or above rr_ptr, then
  // wrap to the ones below it; lowest index wins inside each pass.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_data  = '0;
    if (vsync && req[VBL_REQ]) begin
      win_valid       = 1'b1;
      win_idx         = PTR_W'(VBL_REQ);
      win_oh[VBL_REQ] = 1'b1;
      win_we          = req_we[VBL_REQ];
      win_addr        = req_addr[VBL_REQ*ADDR_W +: ADDR_W];
      win_data        = req_wdata[VBL_REQ*DATA_W +: DATA_W];
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_valid && req[i] && (PTR_W'(i) >= rr_ptr_q)) begin
          win_valid = 1'b1;
          win_idx   = PTR_W'(i);
          win_oh[i] = 1'b1;
          win_we    = req_we[i];
          win_addr  = req_addr[i*ADDR_W +: ADDR_W];
          win_data  = req_wdata[i*DATA_W +: DATA_W];
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!win_valid && req[i]) begin
          win_valid = 1'b1;
          win_idx   = PTR_W'(i);
          win_oh[i] = 1'b1;
          win_we    = req_we[i];
          win_addr  = req_addr[i*ADDR_W +: ADDR_W];
          win_data  = req_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Next-state and registered-output logic. bus_en/bus_rw/gnt/rvalid default
  // low so they can only pulse for the single cycle the state sets them.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    bus_en_d   = 1'b0;
    bus_rw_d   = 1'b0;
    bus_addr_d = bus_addr_q;
    bus_do_d   = bus_do_q;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d    = S_ISSUE;
          gnt_d      = win_oh;
          bus_en_d   = 1'b1;
          bus_rw_d   = win_we;
          bus_addr_d = win_addr;
          bus_do_d   = win_data;
          owner_d    = win_idx;
          rr_ptr_d   = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + PTR_W'(1);
        end
      end
      S_ISSUE: begin
        // bus_rw_q still holds the direction of the transaction being issued.
        if (bus_rw_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 3'd1;
        end
      end
      S_WAIT: begin
        // cnt counts cycles since the strobe; bus_di is valid when it
        // reaches READ_LAT and is captured on that cycle's closing edge.
        if (cnt_q == 3'(READ_LAT)) begin
          state_d = S_RESP;
          rdata_d = bus_di;
          for (int i = 0; i < NREQ; i++) begin
            rvalid_d[i] = (owner_q == PTR_W'(i));
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      bus_en_q   <= 1'b0;
      bus_rw_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_do_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      bus_en_q   <= bus_en_d;
      bus_rw_q   <= bus_rw_d;
      bus_addr_q <= bus_addr_d;
      bus_do_q   <= bus_do_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign bus_en    = bus_en_q;
  assign bus_rw    = bus_rw_q;
  assign bus_addr  = bus_addr_q;
  assign bus_do    = bus_do_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vbus_arbiter
//   Two arbiters: u_dut (READ_LAT=1) driven by a table of directed single
//   transactions plus hand-written reset and round-robin sequences, and u_dut3
//   (READ_LAT=3) driven with random traffic against an arbitration model and a
//   read-data scoreboard. Each arbiter talks to a small 16-entry bus memory that
//   only presents valid bus_di in the read-latency cycle (0xEE otherwise).
// -----------------------------------------------------------------------------
module tb_vbus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT with READ_LAT=1 ----------------
  logic        vsync;
  logic [2:0]  req, req_we;
  logic [47:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata, bus_do, bus_di;
  logic        bus_en, bus_rw, busy;
  logic [15:0] bus_addr;
  logic [1:0]  dbg_state;

  vbus_arbiter #(.NREQ(3), .ADDR_W(16), .DATA_W(8), .READ_LAT(1), .VBL_REQ(0)) u_dut (
    .clk(clk), .reset(reset), .vsync(vsync), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .bus_en(bus_en), .bus_rw(bus_rw), .bus_addr(bus_addr),
    .bus_do(bus_do), .bus_di(bus_di), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- DUT with READ_LAT=3 ----------------
  logic        vsync_3;
  logic [2:0]  req_3, req_we_3;
  logic [47:0] req_addr_3;
  logic [23:0] req_wdata_3;
  logic [2:0]  gnt_3, rvalid_3;
  logic [7:0]  rdata_3, bus_do_3, bus_di_3;
  logic        bus_en_3, bus_rw_3, busy_3;
  logic [15:0] bus_addr_3;
  logic [1:0]  dbg_state_3;

  vbus_arbiter #(.NREQ(3), .ADDR_W(16), .DATA_W(8), .READ_LAT(3), .VBL_REQ(0)) u_dut3 (
    .clk(clk), .reset(reset), .vsync(vsync_3), .req(req_3), .req_we(req_we_3),
    .req_addr(req_addr_3), .req_wdata(req_wdata_3), .gnt(gnt_3), .rvalid(rvalid_3),
    .rdata(rdata_3), .bus_en(bus_en_3), .bus_rw(bus_rw_3), .bus_addr(bus_addr_3),
    .bus_do(bus_do_3), .bus_di(bus_di_3), .busy(busy_3), .dbg_state(dbg_state_3)
  );

  // ---------------- bus memory models ----------------
  logic [7:0] mem1[16];
  logic [7:0] mem3[16];
  logic       en_sh1;
  logic [2:0] en_sh3;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        mem1[k] <= 8'h46 + 8'(k);
        mem3[k] <= 8'h46 + 8'(k);
      end
      en_sh1 <= 1'b0;
      en_sh3 <= 3'b000;
    end else begin
      en_sh1 <= bus_en;
      en_sh3 <= {en_sh3[1:0], bus_en_3};
      if (bus_en && bus_rw) mem1[bus_addr[3:0]] <= bus_do;
      if (bus_en_3 && bus_rw_3) mem3[bus_addr_3[3:0]] <= bus_do_3;
    end
  end

  assign bus_di   = en_sh1    ? mem1[bus_addr[3:0]]   : 8'hEE;
  assign bus_di_3 = en_sh3[2] ? mem3[bus_addr_3[3:0]] : 8'hEE;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Protocol invariants on both arbiters, every cycle out of reset.
  logic prev_en1, prev_en3;
  always @(negedge clk) begin
    if (reset) begin
      prev_en1 = 1'b0;
      prev_en3 = 1'b0;
    end else begin
      check("inv_gnt_onehot",    64'($onehot0(gnt)),      64'd1);
      check("inv_rvalid_onehot", 64'($onehot0(rvalid)),   64'd1);
      check("inv_en_single",     64'(bus_en & prev_en1),  64'd0);
      check("inv_rw_outside",    64'(bus_rw & ~bus_en),   64'd0);
      check("inv3_gnt_onehot",   64'($onehot0(gnt_3)),    64'd1);
      check("inv3_rvalid_onehot",64'($onehot0(rvalid_3)), 64'd1);
      check("inv3_en_single",    64'(bus_en_3 & prev_en3),64'd0);
      check("inv3_rw_outside",   64'(bus_rw_3 & ~bus_en_3), 64'd0);
      prev_en1 = bus_en;
      prev_en3 = bus_en_3;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // ---------------- directed vector table ----------------
  // Requester i presents addr a+i, data d+i. Expected values hand-computed
  // from the round-robin pointer carried across the rows (starts at 0).
  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic        vsync;
    logic [15:0] a;
    logic [7:0]  d;
    logic [2:0]  exp_gnt;
    logic [15:0] exp_addr;
    logic [7:0]  exp_do;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t        vecs[13];
  logic        rd;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_mem3[16];
  logic [15:0] a_r[3];
  logic [7:0]  d_r[3];
  logic [2:0]  mask, wem;
  logic        vs;
  int          w, rr_m, lat, b;

  initial begin
    //         req     we      vs    a         d       gnt     addr      do     rdata
    vecs[0]  = '{3'b010, 3'b010, 1'b0, 16'hFC02, 8'h04, 3'b010, 16'hFC03, 8'h05, 8'h00};
    vecs[1]  = '{3'b100, 3'b000, 1'b0, 16'hFBF6, 8'h00, 3'b100, 16'hFBF8, 8'h02, 8'h4E};
    vecs[2]  = '{3'b111, 3'b111, 1'b0, 16'h1000, 8'h10, 3'b001, 16'h1000, 8'h10, 8'h00};
    vecs[3]  = '{3'b111, 3'b111, 1'b0, 16'h2000, 8'h20, 3'b010, 16'h2001, 8'h21, 8'h00};
    vecs[4]  = '{3'b101, 3'b000, 1'b0, 16'h0000, 8'h00, 3'b100, 16'h0002, 8'h02, 8'h48};
    vecs[5]  = '{3'b001, 3'b001, 1'b0, 16'h3000, 8'h30, 3'b001, 16'h3000, 8'h30, 8'h00};
    vecs[6]  = '{3'b011, 3'b000, 1'b1, 16'h0000, 8'h00, 3'b001, 16'h0000, 8'h00, 8'h30};
    vecs[7]  = '{3'b011, 3'b011, 1'b0, 16'h4000, 8'h40, 3'b010, 16'h4001, 8'h41, 8'h00};
    vecs[8]  = '{3'b001, 3'b000, 1'b1, 16'h0001, 8'h00, 3'b001, 16'h0001, 8'h00, 8'h41};
    vecs[9]  = '{3'b100, 3'b000, 1'b1, 16'h0001, 8'h00, 3'b100, 16'h0003, 8'h02, 8'h05};
    vecs[10] = '{3'b110, 3'b110, 1'b0, 16'h5005, 8'hF0, 3'b010, 16'h5006, 8'hF1, 8'h00};
    vecs[11] = '{3'b011, 3'b000, 1'b0, 16'h5004, 8'h00, 3'b001, 16'h5004, 8'h00, 8'h4A};
    vecs[12] = '{3'b001, 3'b000, 1'b0, 16'h5006, 8'h00, 3'b001, 16'h5006, 8'h00, 8'hF1};

    reset = 1'b1;
    vsync = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    vsync_3 = 1'b0; req_3 = '0; req_we_3 = '0; req_addr_3 = '0; req_wdata_3 = '0;

    // ---- reset values ----
    repeat (2) @(negedge clk);
    check("rst_outputs", {gnt, rvalid, rdata, bus_en, bus_rw, bus_addr, bus_do, busy}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst3_outputs", {gnt_3, rvalid_3, rdata_3, bus_en_3, bus_rw_3, bus_addr_3, bus_do_3, busy_3}, 64'd0);
    reset = 1'b0;

    // ---- table of single transactions on u_dut ----
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      vsync  = vecs[v].vsync;
      req    = vecs[v].req;
      req_we = vecs[v].we;
      for (int i = 0; i < 3; i++) begin
        req_addr[i*16 +: 16] = vecs[v].a + 16'(i);
        req_wdata[i*8 +: 8]  = vecs[v].d + 8'(i);
      end
      rd = ((vecs[v].exp_gnt & vecs[v].we) == 3'b000);
      @(negedge clk);
      check($sformatf("v%0d_gnt", v),    64'(gnt),      64'(vecs[v].exp_gnt));
      check($sformatf("v%0d_bus_en", v), 64'(bus_en),   64'd1);
      check($sformatf("v%0d_bus_rw", v), 64'(bus_rw),   64'(!rd));
      check($sformatf("v%0d_addr", v),   64'(bus_addr), 64'(vecs[v].exp_addr));
      check($sformatf("v%0d_do", v),     64'(bus_do),   64'(vecs[v].exp_do));
      req = '0;
      vsync = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_en_off", v), 64'({bus_en, bus_rw, gnt}), 64'd0);
      if (rd) begin
        check($sformatf("v%0d_addr_hold", v), 64'(bus_addr), 64'(vecs[v].exp_addr));
        check($sformatf("v%0d_rvalid_early", v), 64'(rvalid), 64'd0);
        @(negedge clk);
        check($sformatf("v%0d_rvalid", v), 64'(rvalid), 64'(vecs[v].exp_gnt));
        check($sformatf("v%0d_rdata", v),  64'(rdata),  64'(vecs[v].exp_rdata));
        @(negedge clk);
        check($sformatf("v%0d_rdata_hold", v), 64'(rdata), 64'(vecs[v].exp_rdata));
      end
      check($sformatf("v%0d_idle", v), 64'(busy), 64'd0);
    end

    // ---- reset in the middle of a read: outputs clear at once, no rvalid later ----
    @(negedge clk);
    req = 3'b100; req_we = 3'b000; req_addr[32 +: 16] = 16'h0008;
    @(negedge clk);
    check("t1_gnt", 64'(gnt), 64'(3'b100));
    req = '0;
    @(negedge clk);
    check("t1_in_wait", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    #1;
    check("t1_cleared", {gnt, rvalid, rdata, bus_en, bus_rw, bus_addr, bus_do, busy}, 64'd0);
    check("t1_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t1_no_rvalid_%0d", c), 64'({rvalid, busy}), 64'd0);
    end

    // ---- round robin with req=111 held: one write every 2 cycles, order 0,1,2 ----
    @(negedge clk);
    req = 3'b111; req_we = 3'b111; vsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*16 +: 16] = 16'h0009 + 16'(i);
      req_wdata[i*8 +: 8]  = 8'hA0 + 8'(i);
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check($sformatf("t4_gnt_%0d", k), 64'({gnt, bus_en}), 64'({3'b001 << (k % 3), 1'b1}));
      @(negedge clk);
      check($sformatf("t4_gap_%0d", k), 64'({gnt, bus_en, busy}), 64'd0);
    end
    req = '0;
    @(negedge clk);
    check("t4_stop", 64'({gnt, busy}), 64'd0);

    // ---- random traffic on u_dut3 (READ_LAT=3) with model and scoreboard ----
    for (int k = 0; k < 16; k++) exp_mem3[k] = 8'h46 + 8'(k);
    rr_m = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      mask = 3'($urandom_range(1, 7));
      wem  = 3'($urandom_range(0, 7));
      vs   = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) begin
        a_r[i] = 16'($urandom);
        d_r[i] = 8'($urandom);
        req_addr_3[i*16 +: 16] = a_r[i];
        req_wdata_3[i*8 +: 8]  = d_r[i];
      end
      req_3 = mask; req_we_3 = wem; vsync_3 = vs;
      if (vs && mask[0]) begin
        w = 0;
      end else begin
        w = -1;
        for (int k = 0; k < 3; k++) begin
          if (w < 0 && mask[(rr_m + k) % 3]) w = (rr_m + k) % 3;
        end
      end
      rr_m = (w + 1) % 3;
      @(negedge clk);
      check($sformatf("r%0d_gnt", t),  64'(gnt_3),      64'(3'b001 << w));
      check($sformatf("r%0d_addr", t), 64'(bus_addr_3), 64'(a_r[w]));
      check($sformatf("r%0d_rw", t),   64'(bus_rw_3),   64'(wem[w]));
      req_3 = '0; vsync_3 = 1'b0;
      if (wem[w]) begin
        check($sformatf("r%0d_do", t), 64'(bus_do_3), 64'(d_r[w]));
        exp_mem3[a_r[w][3:0]] = d_r[w];
      end else begin
        exp_q.push_back(exp_mem3[a_r[w][3:0]]);
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (rvalid_3 == 3'b000 && lat < 10);
        check($sformatf("r%0d_latency", t), 64'(lat), 64'd4);
        check($sformatf("r%0d_rvalid", t), 64'(rvalid_3), 64'(3'b001 << w));
        if (exp_q.size() > 0) begin
          check($sformatf("r%0d_rdata", t), 64'(rdata_3), 64'(exp_q.pop_front()));
        end
      end
      b = 0;
      while (busy_3 && b < 10) begin
        @(negedge clk);
        b++;
      end
      check($sformatf("r%0d_idle", t), 64'(busy_3), 64'd0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
